// File: rtl/clk_gen_ctrl_pkg.sv
// Shared types, reset defaults and request validation for the clock
// generator configuration controller.
package clk_gen_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_STOP      = 2'd1,
    ST_LOAD      = 2'd2,
    ST_WAIT_EDGE = 2'd3
  } ctrl_state_e;

  typedef logic [31:0] cfg_word_t;

  localparam cfg_word_t DEF_FREQ   = 32'd125000;
  localparam cfg_word_t DEF_EXPECT = 32'd2048;

  // Widened to 33 bits so that doubling a large denominator cannot wrap.
  function automatic logic cfg_is_valid(input cfg_word_t freq, input cfg_word_t expect_clk);
    logic [32:0] freq_ext;
    logic [32:0] twice_expect;
    freq_ext     = {1'b0, freq};
    twice_expect = {expect_clk, 1'b0};
    return (expect_clk != 32'd0) && (freq_ext >= twice_expect);
  endfunction

endpackage

// File: rtl/clk_edge_watchdog.sv
// Rising-edge detector on the divider feedback clock plus the lock timeout
// counter; both are only meaningful while en is high.
module clk_edge_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic div_clk,
  output logic edge_seen,
  output logic timeout
);
  localparam int unsigned   CW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC);

  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          div_prev_q, div_prev_d;

  // Counter restarts from zero each time the wait window opens.
  always_comb begin
    cnt_inc    = cnt_q + CW'(1'b1);
    div_prev_d = div_clk;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == LIMIT) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_inc;
    end
    edge_seen = en & div_clk & ~div_prev_q;
    timeout   = en && (cnt_inc == LIMIT);
  end

  // Counter and delayed feedback sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      div_prev_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_prev_q <= div_prev_d;
    end
  end

endmodule

// File: rtl/clk_gen_cfg_ctrl.sv
// Reconfiguration sequencer for the clock divider: validate request, stop the
// divider, load new ratio with a config reset, then wait for the first edge.
module clk_gen_cfg_ctrl #(
  parameter int unsigned STOP_CYC    = 4,
  parameter int unsigned RST_CYC     = 2,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter logic [31:0] DEF_FREQ    = clk_gen_ctrl_pkg::DEF_FREQ,
  parameter logic [31:0] DEF_EXPECT  = clk_gen_ctrl_pkg::DEF_EXPECT
) (
  input  logic        I_sys_clk,
  input  logic        I_rst,
  input  logic        I_cfg_valid,
  output logic        O_cfg_ready,
  input  logic [31:0] I_cfg_freq,
  input  logic [31:0] I_cfg_expect,
  input  logic        I_div_exp_clk,
  output logic        O_gen_stop,
  output logic        O_rst_cfg,
  output logic [31:0] O_sys_clk_freq,
  output logic [31:0] O_expect_clk,
  output logic        O_cfg_done,
  output logic        O_cfg_err,
  output logic        O_locked
);
  import clk_gen_ctrl_pkg::*;

  localparam int unsigned   PH_MAX    = (STOP_CYC > RST_CYC) ? STOP_CYC : RST_CYC;
  localparam int unsigned   PW        = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [PW-1:0] STOP_LAST = PW'(STOP_CYC - 1);
  localparam logic [PW-1:0] RST_LAST  = PW'(RST_CYC - 1);

  ctrl_state_e   state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  cfg_word_t     cap_freq_q, cap_freq_d;
  cfg_word_t     cap_expect_q, cap_expect_d;
  cfg_word_t     freq_q, freq_d;
  cfg_word_t     expect_q, expect_d;
  logic          ready_q, ready_d;
  logic          gen_stop_q, gen_stop_d;
  logic          rst_cfg_q, rst_cfg_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          locked_q, locked_d;

  logic          req_ok;
  logic          wait_active;
  logic          edge_seen;
  logic          timeout;

  assign req_ok      = cfg_is_valid(I_cfg_freq, I_cfg_expect);
  assign wait_active = (state_q == ST_WAIT_EDGE);

  clk_edge_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk      (I_sys_clk),
    .rst      (I_rst),
    .en       (wait_active),
    .div_clk  (I_div_exp_clk),
    .edge_seen(edge_seen),
    .timeout  (timeout)
  );

  // Sequencer next state and next registered outputs.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    cap_freq_d   = cap_freq_q;
    cap_expect_d = cap_expect_q;
    freq_d       = freq_q;
    expect_d     = expect_q;
    gen_stop_d   = gen_stop_q;
    rst_cfg_d    = rst_cfg_q;
    locked_d     = locked_q;
    done_d       = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (I_cfg_valid && ready_q) begin
          if (req_ok) begin
            cap_freq_d   = I_cfg_freq;
            cap_expect_d = I_cfg_expect;
            state_d      = ST_STOP;
            phase_d      = '0;
            gen_stop_d   = 1'b1;
            locked_d     = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STOP: begin
        if (phase_q == STOP_LAST) begin
          state_d   = ST_LOAD;
          phase_d   = '0;
          freq_d    = cap_freq_q;
          expect_d  = cap_expect_q;
          rst_cfg_d = 1'b1;
        end else begin
          phase_d = phase_q + PW'(1'b1);
        end
      end
      ST_LOAD: begin
        if (phase_q == RST_LAST) begin
          state_d    = ST_WAIT_EDGE;
          phase_d    = '0;
          gen_stop_d = 1'b0;
          rst_cfg_d  = 1'b0;
        end else begin
          phase_d = phase_q + PW'(1'b1);
        end
      end
      ST_WAIT_EDGE: begin
        // An edge landing on the timeout cycle still counts as a lock.
        if (edge_seen) begin
          done_d   = 1'b1;
          locked_d = 1'b1;
          state_d  = ST_IDLE;
        end else if (timeout) begin
          err_d    = 1'b1;
          locked_d = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_WAIT_EDGE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        gen_stop_d = 1'b0;
        rst_cfg_d  = 1'b0;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      cap_freq_q   <= '0;
      cap_expect_q <= '0;
      freq_q       <= DEF_FREQ;
      expect_q     <= DEF_EXPECT;
      ready_q      <= 1'b0;
      gen_stop_q   <= 1'b0;
      rst_cfg_q    <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cap_freq_q   <= cap_freq_d;
      cap_expect_q <= cap_expect_d;
      freq_q       <= freq_d;
      expect_q     <= expect_d;
      ready_q      <= ready_d;
      gen_stop_q   <= gen_stop_d;
      rst_cfg_q    <= rst_cfg_d;
      done_q       <= done_d;
      err_q        <= err_d;
      locked_q     <= locked_d;
    end
  end

  assign O_cfg_ready    = ready_q;
  assign O_gen_stop     = gen_stop_q;
  assign O_rst_cfg      = rst_cfg_q;
  assign O_sys_clk_freq = freq_q;
  assign O_expect_clk   = expect_q;
  assign O_cfg_done     = done_q;
  assign O_cfg_err      = err_q;
  assign O_locked       = locked_q;

endmodule

// File: tb/tb_clk_gen_cfg_ctrl.sv
// Bench for clk_gen_cfg_ctrl: a behavioural fractional divider closes the loop,
// and a request-level reference model predicts every outcome.
module tb_clk_gen_cfg_ctrl;
  localparam int          TIMEOUT_CYC = 1024;
  localparam logic [31:0] DEF_F       = 32'd125000;
  localparam logic [31:0] DEF_E       = 32'd2048;

  logic        clk = 1'b0, rst = 1'b1, cfg_valid = 1'b0;
  logic [31:0] cfg_freq = 32'd0, cfg_exp = 32'd0;
  logic        div_clk = 1'b0, force_low = 1'b0;
  logic        cfg_ready, gen_stop, rst_cfg, cfg_done, cfg_err, locked;
  logic [31:0] sys_freq, exp_clk;

  int n_cmp = 0, n_fail = 0;
  logic [31:0] ref_freq = DEF_F, ref_exp = DEF_E;
  logic        ref_locked = 1'b0;

  clk_gen_cfg_ctrl dut (
    .I_sys_clk(clk), .I_rst(rst), .I_cfg_valid(cfg_valid), .O_cfg_ready(cfg_ready),
    .I_cfg_freq(cfg_freq), .I_cfg_expect(cfg_exp), .I_div_exp_clk(div_clk),
    .O_gen_stop(gen_stop), .O_rst_cfg(rst_cfg), .O_sys_clk_freq(sys_freq),
    .O_expect_clk(exp_clk), .O_cfg_done(cfg_done), .O_cfg_err(cfg_err), .O_locked(locked)
  );

  always #5 clk = ~clk;

  // Stand-in divider: output toggles every freq/(2*expect) sys cycles on average.
  longint acc = 0;
  always @(posedge clk) begin
    if (rst || gen_stop || rst_cfg || force_low || exp_clk == 32'd0) begin
      acc <= 0; div_clk <= 1'b0;
    end else if (acc + 2 * longint'(exp_clk) >= longint'(sys_freq)) begin
      acc <= acc + 2 * longint'(exp_clk) - longint'(sys_freq); div_clk <= ~div_clk;
    end else begin
      acc <= acc + 2 * longint'(exp_clk);
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_stop_only = 0, n_gen_stop = 0, n_rst_cfg = 0, n_done = 0, n_err = 0, n_both = 0;
  int t_wait = 0, t_done = 0, t_err = 0;
  logic [31:0] load_freq = 32'd0, load_exp = 32'd0;
  logic prev_gs = 1'b0, prev_rc = 1'b0, prev_div = 1'b0;
  int rise_t[$];

  // Event monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (gen_stop === 1'b1 && rst_cfg === 1'b0) n_stop_only++;
    if (gen_stop === 1'b1) n_gen_stop++;
    if (rst_cfg === 1'b1) n_rst_cfg++;
    if (cfg_done === 1'b1) begin n_done++; t_done = cyc; end
    if (cfg_err === 1'b1) begin n_err++; t_err = cyc; end
    if (cfg_done === 1'b1 && cfg_err === 1'b1) n_both++;
    if (prev_gs === 1'b1 && gen_stop === 1'b0) t_wait = cyc;
    if (prev_rc === 1'b0 && rst_cfg === 1'b1) begin load_freq = sys_freq; load_exp = exp_clk; end
    if (prev_div === 1'b0 && div_clk === 1'b1) rise_t.push_back(cyc);
    prev_gs = gen_stop; prev_rc = rst_cfg; prev_div = div_clk;
  end

  function automatic bit model_valid(input logic [31:0] f, input logic [31:0] e);
    return (e != 32'd0) && (longint'(f) >= 2 * longint'(e));
  endfunction

  // Sys cycles from divider release to its first rising output edge.
  function automatic longint model_first_edge(input logic [31:0] f, input logic [31:0] e);
    return (longint'(f) + 2 * longint'(e) - 1) / (2 * longint'(e));
  endfunction

  task automatic step(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic do_request(input logic [31:0] f, input logic [31:0] e);
    int budget = 0;
    cfg_freq = f; cfg_exp = e; cfg_valid = 1'b1;
    while (cfg_ready !== 1'b1 && budget < 3000) begin step(1); budget++; end
    n_cmp++;
    if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL req_accept: ready=%b after %0d cycles, need 1", cfg_ready, budget); end
    step(1);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int budget = 0;
    while (cfg_ready !== 1'b1 && budget < 3000) begin step(1); budget++; end
    n_cmp++;
    if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL idle_return: ready=%b after %0d cycles, need 1", cfg_ready, budget); end
  endtask

  task automatic test_reset();
    rst = 1'b1; step(3);
    n_cmp++; if ({cfg_ready, gen_stop, rst_cfg, cfg_done, cfg_err, locked} !== 6'b0) begin n_fail++;
      $display("FAIL reset_ctrl: rdy/stop/rcfg/done/err/lock=%b, need 000000", {cfg_ready, gen_stop, rst_cfg, cfg_done, cfg_err, locked}); end
    n_cmp++; if (sys_freq !== DEF_F || exp_clk !== DEF_E) begin n_fail++;
      $display("FAIL reset_values: got %0d/%0d, need %0d/%0d", sys_freq, exp_clk, DEF_F, DEF_E); end
    rst = 1'b0; step(1);
    n_cmp++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b, need 1", cfg_ready); end
    ref_freq = DEF_F; ref_exp = DEF_E; ref_locked = 1'b0;
  endtask

  task automatic test_nominal();
    int d0 = n_done, e0 = n_err, s0 = n_stop_only, g0 = n_gen_stop, r0 = n_rst_cfg, base, span;
    longint k = model_first_edge(32'd125000, 32'd2048);
    real want_span;
    do_request(32'd125000, 32'd2048);
    n_cmp++; if ({cfg_ready, gen_stop, locked} !== 3'b010) begin n_fail++;
      $display("FAIL nom_enter_stop: rdy/stop/lock=%b, need 010", {cfg_ready, gen_stop, locked}); end
    wait_idle(); step(2);
    ref_freq = 32'd125000; ref_exp = 32'd2048; ref_locked = 1'b1;
    n_cmp++; if (n_stop_only - s0 !== 4) begin n_fail++; $display("FAIL nom_stop_len: got %0d, need 4", n_stop_only - s0); end
    n_cmp++; if (n_rst_cfg - r0 !== 2) begin n_fail++; $display("FAIL nom_rst_cfg_len: got %0d, need 2", n_rst_cfg - r0); end
    n_cmp++; if (n_gen_stop - g0 !== 6) begin n_fail++; $display("FAIL nom_gen_stop_total: got %0d, need 6", n_gen_stop - g0); end
    n_cmp++; if (load_freq !== ref_freq || load_exp !== ref_exp) begin n_fail++;
      $display("FAIL nom_load_values: got %0d/%0d, need %0d/%0d", load_freq, load_exp, ref_freq, ref_exp); end
    n_cmp++; if (n_done - d0 !== 1 || n_err - e0 !== 0) begin n_fail++;
      $display("FAIL nom_pulses: done=%0d err=%0d, need 1/0", n_done - d0, n_err - e0); end
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL nom_locked: got %b, need 1", locked); end
    n_cmp++; if (longint'(t_done - t_wait) !== k + 1) begin n_fail++;
      $display("FAIL nom_lock_latency: got %0d, need %0d", t_done - t_wait, k + 1); end
    base = rise_t.size();
    for (int i = 0; i < 3000 && rise_t.size() < base + 33; i++) step(1);
    want_span = 32.0 * 125000.0 / 2048.0;
    span = (rise_t.size() >= base + 33) ? rise_t[base + 32] - rise_t[base] : -1;
    n_cmp++; if (span < 0 || (real'(span) - want_span) > 1.0 || (want_span - real'(span)) > 1.0) begin n_fail++;
      $display("FAIL nom_period: 32 periods span %0d, need about %0.3f", span, want_span); end
  endtask

  task automatic test_invalid();
    logic [31:0] fs[3] = '{32'd100, 32'd100, 32'hFFFF_FFFF};
    logic [31:0] es[3] = '{32'd0, 32'd51, 32'h8000_0000};
    for (int i = 0; i < 3; i++) begin
      int d0 = n_done, e0 = n_err;
      do_request(fs[i], es[i]);
      n_cmp++; if ({cfg_ready, gen_stop, cfg_err} !== 3'b101) begin n_fail++;
        $display("FAIL inv%0d_idle: rdy/stop/err=%b, need 101", i, {cfg_ready, gen_stop, cfg_err}); end
      step(2);
      n_cmp++; if (n_err - e0 !== 1 || n_done - d0 !== 0) begin n_fail++;
        $display("FAIL inv%0d_pulses: err=%0d done=%0d, need 1/0", i, n_err - e0, n_done - d0); end
      n_cmp++; if (sys_freq !== ref_freq || exp_clk !== ref_exp || locked !== ref_locked) begin n_fail++;
        $display("FAIL inv%0d_unchanged: got %0d/%0d lock %b, need %0d/%0d lock %b", i, sys_freq, exp_clk, locked, ref_freq, ref_exp, ref_locked); end
    end
  endtask

  task automatic test_boundary();
    int d0 = n_done, e0 = n_err;
    do_request(32'd100, 32'd50);
    n_cmp++; if (gen_stop !== 1'b1) begin n_fail++; $display("FAIL bnd_accepted: gen_stop=%b, need 1", gen_stop); end
    wait_idle(); step(2);
    ref_freq = 32'd100; ref_exp = 32'd50; ref_locked = 1'b1;
    n_cmp++; if (n_done - d0 !== 1 || n_err - e0 !== 0 || locked !== 1'b1 || sys_freq !== ref_freq) begin n_fail++;
      $display("FAIL bnd_done: done=%0d err=%0d lock=%b freq=%0d, need 1/0/1/100", n_done - d0, n_err - e0, locked, sys_freq); end
    n_cmp++; if (t_done - t_wait !== 2) begin n_fail++; $display("FAIL bnd_latency: got %0d, need 2", t_done - t_wait); end
  endtask

  task automatic test_timeout();
    int d0 = n_done, e0 = n_err;
    force_low = 1'b1;
    do_request(32'd1000, 32'd10);
    wait_idle(); step(2);
    force_low = 1'b0;
    ref_freq = 32'd1000; ref_exp = 32'd10; ref_locked = 1'b0;
    n_cmp++; if (n_err - e0 !== 1 || n_done - d0 !== 0) begin n_fail++;
      $display("FAIL to_pulses: err=%0d done=%0d, need 1/0", n_err - e0, n_done - d0); end
    n_cmp++; if (t_err - t_wait !== TIMEOUT_CYC) begin n_fail++;
      $display("FAIL to_latency: got %0d, need %0d", t_err - t_wait, TIMEOUT_CYC); end
    n_cmp++; if (locked !== 1'b0 || sys_freq !== ref_freq || exp_clk !== ref_exp) begin n_fail++;
      $display("FAIL to_state: lock=%b values %0d/%0d, need 0 and %0d/%0d", locked, sys_freq, exp_clk, ref_freq, ref_exp); end
  endtask

  task automatic test_edge_vs_timeout();
    int d0 = n_done, e0 = n_err;
    do_request(32'd2046, 32'd1);
    wait_idle(); step(2);
    n_cmp++; if (n_done - d0 !== 1 || n_err - e0 !== 0 || t_done - t_wait !== TIMEOUT_CYC || locked !== 1'b1) begin n_fail++;
      $display("FAIL evt_edge_wins: done=%0d err=%0d lat=%0d lock=%b, need 1/0/%0d/1", n_done - d0, n_err - e0, t_done - t_wait, locked, TIMEOUT_CYC); end
    d0 = n_done; e0 = n_err;
    do_request(32'd2048, 32'd1);
    wait_idle(); step(2);
    ref_freq = 32'd2048; ref_exp = 32'd1; ref_locked = 1'b0;
    n_cmp++; if (n_done - d0 !== 0 || n_err - e0 !== 1 || t_err - t_wait !== TIMEOUT_CYC || locked !== 1'b0) begin n_fail++;
      $display("FAIL evt_late_edge: done=%0d err=%0d lat=%0d lock=%b, need 0/1/%0d/0", n_done - d0, n_err - e0, t_err - t_wait, locked, TIMEOUT_CYC); end
  endtask

  task automatic test_back_to_back();
    int d0 = n_done, budget = 0;
    do_request(32'd50000, 32'd1000);
    cfg_freq = 32'd60000; cfg_exp = 32'd1000; cfg_valid = 1'b1;
    step(1);
    n_cmp++; if (cfg_ready !== 1'b0 || gen_stop !== 1'b1) begin n_fail++;
      $display("FAIL b2b_busy: rdy=%b stop=%b, need 0/1", cfg_ready, gen_stop); end
    while (cfg_ready !== 1'b1 && budget < 3000) begin step(1); budget++; end
    n_cmp++; if (n_done - d0 !== 1 || sys_freq !== 32'd50000 || load_freq !== 32'd50000) begin n_fail++;
      $display("FAIL b2b_first: done=%0d freq=%0d load=%0d, need 1/50000/50000", n_done - d0, sys_freq, load_freq); end
    do_request(32'd60000, 32'd1000);
    n_cmp++; if (cfg_ready !== 1'b0 || gen_stop !== 1'b1) begin n_fail++;
      $display("FAIL b2b_second_accept: rdy=%b stop=%b, need 0/1", cfg_ready, gen_stop); end
    wait_idle(); step(2);
    ref_freq = 32'd60000; ref_exp = 32'd1000; ref_locked = 1'b1;
    n_cmp++; if (n_done - d0 !== 2 || sys_freq !== ref_freq || locked !== 1'b1) begin n_fail++;
      $display("FAIL b2b_second: done=%0d freq=%0d lock=%b, need 2/60000/1", n_done - d0, sys_freq, locked); end
  endtask

  task automatic test_rst_mid();
    int d0, e0, budget = 0;
    do_request(32'd200000, 32'd1000);
    while (rst_cfg !== 1'b1 && budget < 20) begin step(1); budget++; end
    n_cmp++; if (rst_cfg !== 1'b1 || gen_stop !== 1'b1 || sys_freq !== 32'd200000) begin n_fail++;
      $display("FAIL rm_in_load: rcfg=%b stop=%b freq=%0d, need 1/1/200000", rst_cfg, gen_stop, sys_freq); end
    d0 = n_done; e0 = n_err;
    rst = 1'b1; step(1);
    n_cmp++; if (sys_freq !== DEF_F || exp_clk !== DEF_E || {cfg_ready, gen_stop, rst_cfg, locked} !== 4'b0) begin n_fail++;
      $display("FAIL rm_abort: got %0d/%0d ctrl %b, need %0d/%0d ctrl 0000", sys_freq, exp_clk, {cfg_ready, gen_stop, rst_cfg, locked}, DEF_F, DEF_E); end
    rst = 1'b0; step(3);
    ref_freq = DEF_F; ref_exp = DEF_E; ref_locked = 1'b0;
    n_cmp++; if (n_done - d0 !== 0 || n_err - e0 !== 0 || cfg_ready !== 1'b1) begin n_fail++;
      $display("FAIL rm_no_pulse: done=%0d err=%0d rdy=%b, need 0/0/1", n_done - d0, n_err - e0, cfg_ready); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 14; i++) begin
      logic [31:0] rf, re;
      int mode, d0, e0, s0, r0, want_done, want_err;
      bit v;
      longint k;
      mode = $urandom_range(0, 3);
      if (mode == 0) begin
        re = $urandom_range(0, 40);
        rf = (re == 32'd0) ? $urandom : $urandom_range(0, 2 * re - 1);
      end else if (mode == 3) begin
        re = 32'h8000_0000 | $urandom;
        rf = 32'hF000_0000 | $urandom;
      end else begin
        re = $urandom_range(1, 40);
        rf = 2 * re * $urandom_range(1, 1100) - $urandom_range(0, 2 * re - 1);
      end
      v = model_valid(rf, re);
      k = v ? model_first_edge(rf, re) : 0;
      want_done = (v && k <= TIMEOUT_CYC - 1) ? 1 : 0;
      want_err  = want_done ? 0 : 1;
      d0 = n_done; e0 = n_err; s0 = n_stop_only; r0 = n_rst_cfg;
      do_request(rf, re);
      wait_idle(); step(2);
      if (v) begin ref_freq = rf; ref_exp = re; ref_locked = (want_done == 1); end
      n_cmp++; if (n_done - d0 !== want_done || n_err - e0 !== want_err) begin n_fail++;
        $display("FAIL rnd%0d_pulses (%0d/%0d): done=%0d err=%0d, need %0d/%0d", i, rf, re, n_done - d0, n_err - e0, want_done, want_err); end
      n_cmp++; if (sys_freq !== ref_freq || exp_clk !== ref_exp || locked !== ref_locked) begin n_fail++;
        $display("FAIL rnd%0d_state: got %0d/%0d lock %b, need %0d/%0d lock %b", i, sys_freq, exp_clk, locked, ref_freq, ref_exp, ref_locked); end
      if (v) begin
        n_cmp++; if (n_stop_only - s0 !== 4 || n_rst_cfg - r0 !== 2) begin n_fail++;
          $display("FAIL rnd%0d_phases: stop=%0d rcfg=%0d, need 4/2", i, n_stop_only - s0, n_rst_cfg - r0); end
        n_cmp++; if (longint'(want_done ? t_done - t_wait : t_err - t_wait) !== (want_done ? k + 1 : longint'(TIMEOUT_CYC))) begin n_fail++;
          $display("FAIL rnd%0d_latency: got %0d, need %0d", i, want_done ? t_done - t_wait : t_err - t_wait, want_done ? k + 1 : longint'(TIMEOUT_CYC)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_invalid();
    test_boundary();
    test_timeout();
    test_edge_vs_timeout();
    test_back_to_back();
    test_rst_mid();
    test_random();
    n_cmp++; if (n_both !== 0) begin n_fail++; $display("FAIL done_err_exclusive: %0d overlapping cycles, need 0", n_both); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
